// File: rtl/keypad_col_decoder_pkg.sv
// Shared keypad definitions: legal row-scan patterns, debounce FSM state codes,
// frame classification and small decode helpers used by the scanner and decoder.
package keypad_col_decoder_pkg;

  localparam logic [3:0] ROW_GAP = 4'b1111;
  localparam logic [3:0] ROW_0   = 4'b1000;
  localparam logic [3:0] ROW_1   = 4'b0100;
  localparam logic [3:0] ROW_2   = 4'b0010;
  localparam logic [3:0] ROW_3   = 4'b0001;

  localparam logic [1:0] ST_IDLE            = 2'd0;
  localparam logic [1:0] ST_CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED         = 2'd2;
  localparam logic [1:0] ST_CONFIRM_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    FRAME_NONE    = 2'd0,
    FRAME_SINGLE  = 2'd1,
    FRAME_MULTI   = 2'd2,
    FRAME_INVALID = 2'd3
  } frame_class_e;

  typedef enum logic [1:0] {
    ROW_KIND_GAP     = 2'd0,
    ROW_KIND_SCAN    = 2'd1,
    ROW_KIND_ILLEGAL = 2'd2
  } row_kind_e;

  function automatic row_kind_e row_kind(input logic [3:0] row);
    row_kind_e kind;
    case (row)
      ROW_GAP:                      kind = ROW_KIND_GAP;
      ROW_0, ROW_1, ROW_2, ROW_3:   kind = ROW_KIND_SCAN;
      default:                      kind = ROW_KIND_ILLEGAL;
    endcase
    return kind;
  endfunction

  // MSB-first one-hot to index: 1000 -> 0 ... 0001 -> 3.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    logic [3:0] r;
    if (v == 4'hF) begin
      r = 4'hF;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_col_decoder_frame_acc.sv
// Frame accumulator: collects column hits over one row-scan frame and reports
// the frame class combinationally on the gap (close) cycle.
module keypad_frame_acc
  import keypad_col_decoder_pkg::*;
(
  input  logic         clk_sec,
  input  logic         rst_n,
  input  logic [3:0]   row_drive,
  input  logic [3:0]   col_in,
  output logic         frame_close,
  output frame_class_e frame_class,
  output logic [3:0]   frame_code
);

  logic       seen_r;
  logic       multi_r;
  logic       invalid_r;
  logic [3:0] code_r;

  row_kind_e  kind_s;
  logic [2:0] ncols_s;
  logic [1:0] row_idx_s;
  logic [1:0] col_idx_s;

  // Decode the current row/column inputs.
  always_comb begin
    kind_s    = row_kind(row_drive);
    ncols_s   = popcount4(col_in);
    row_idx_s = onehot_index(row_drive);
    col_idx_s = onehot_index(col_in);
  end

  // Classify the accumulated frame; only meaningful while frame_close is high.
  always_comb begin
    frame_close = (row_drive == ROW_GAP);
    frame_code  = code_r;
    if (invalid_r) begin
      frame_class = FRAME_INVALID;
    end else if (multi_r) begin
      frame_class = FRAME_MULTI;
    end else if (seen_r) begin
      frame_class = FRAME_SINGLE;
    end else begin
      frame_class = FRAME_NONE;
    end
  end

  // Accumulate hits; the gap cycle clears everything for the next frame.
  always_ff @(posedge clk_sec) begin
    if (!rst_n) begin
      seen_r    <= 1'b0;
      multi_r   <= 1'b0;
      invalid_r <= 1'b0;
      code_r    <= 4'd0;
    end else begin
      case (kind_s)
        ROW_KIND_GAP: begin
          seen_r    <= 1'b0;
          multi_r   <= 1'b0;
          invalid_r <= 1'b0;
          code_r    <= 4'd0;
        end
        ROW_KIND_SCAN: begin
          if (ncols_s == 3'd0) begin
            seen_r <= seen_r;
          end else if ((ncols_s == 3'd1) && !seen_r) begin
            seen_r <= 1'b1;
            code_r <= {row_idx_s, col_idx_s};
          end else begin
            multi_r <= 1'b1;
          end
        end
        default: begin
          invalid_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_col_decoder.sv
// Keypad column decoder: debounces frame classifications from keypad_frame_acc
// into accepted key presses/releases with registered key outputs.
module keypad_col_decoder
  import keypad_col_decoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned COL_W           = 4
) (
  input  logic             clk_sec,
  input  logic             rst_n,
  input  logic [3:0]       row_drive,
  input  logic [COL_W-1:0] col_in,
  output logic [3:0]       key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             multi_err
);

  localparam logic [3:0] DEB_LIMIT = DEBOUNCE_FRAMES[3:0];

  logic         frame_close_s;
  frame_class_e frame_class_s;
  logic [3:0]   frame_code_s;

  logic [1:0]   state_r;
  logic [3:0]   cnt_r;
  logic [3:0]   cand_r;
  logic         discard_r;

  logic [1:0]   state_n_s;
  logic [3:0]   cnt_n_s;
  logic [3:0]   cand_n_s;
  logic [3:0]   cnt_inc_s;
  logic         act_s;
  logic         accept_s;
  logic         release_s;

  keypad_frame_acc u_frame_acc (
    .clk_sec     (clk_sec),
    .rst_n       (rst_n),
    .row_drive   (row_drive),
    .col_in      (col_in),
    .frame_close (frame_close_s),
    .frame_class (frame_class_s),
    .frame_code  (frame_code_s)
  );

  // Debounce next-state logic; evaluated only on non-discarded frame closes.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    cand_n_s  = cand_r;
    accept_s  = 1'b0;
    release_s = 1'b0;
    cnt_inc_s = sat_inc(cnt_r);
    act_s     = frame_close_s && !discard_r;
    if (act_s && (frame_class_s == FRAME_INVALID)) begin
      cnt_n_s = 4'd0;
    end else if (act_s) begin
      case (state_r)
        ST_IDLE: begin
          if (frame_class_s == FRAME_SINGLE) begin
            cand_n_s = frame_code_s;
            cnt_n_s  = 4'd1;
            if (DEB_LIMIT <= 4'd1) begin
              state_n_s = ST_PRESSED;
              accept_s  = 1'b1;
            end else begin
              state_n_s = ST_CONFIRM_PRESS;
            end
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_CONFIRM_PRESS: begin
          if ((frame_class_s == FRAME_SINGLE) && (frame_code_s == cand_r)) begin
            cnt_n_s = cnt_inc_s;
            if (cnt_inc_s >= DEB_LIMIT) begin
              state_n_s = ST_PRESSED;
              accept_s  = 1'b1;
            end else begin
              state_n_s = ST_CONFIRM_PRESS;
            end
          end else if (frame_class_s == FRAME_SINGLE) begin
            cand_n_s = frame_code_s;
            cnt_n_s  = 4'd1;
          end else begin
            state_n_s = ST_IDLE;
            cnt_n_s   = 4'd0;
          end
        end
        ST_PRESSED: begin
          // A second key while pressed is ignored: no rollover.
          if (frame_class_s == FRAME_NONE) begin
            cnt_n_s = 4'd1;
            if (DEB_LIMIT <= 4'd1) begin
              state_n_s = ST_IDLE;
              release_s = 1'b1;
            end else begin
              state_n_s = ST_CONFIRM_RELEASE;
            end
          end else begin
            state_n_s = ST_PRESSED;
          end
        end
        ST_CONFIRM_RELEASE: begin
          if (frame_class_s == FRAME_NONE) begin
            cnt_n_s = cnt_inc_s;
            if (cnt_inc_s >= DEB_LIMIT) begin
              state_n_s = ST_IDLE;
              release_s = 1'b1;
            end else begin
              state_n_s = ST_CONFIRM_RELEASE;
            end
          end else begin
            state_n_s = ST_PRESSED;
            cnt_n_s   = 4'd0;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          cnt_n_s   = 4'd0;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // State, debounce bookkeeping and registered key outputs.
  always_ff @(posedge clk_sec) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      cand_r    <= 4'd0;
      discard_r <= 1'b1;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      cand_r    <= cand_n_s;
      discard_r <= frame_close_s ? 1'b0 : discard_r;
      key_valid <= accept_s;
      multi_err <= act_s && (frame_class_s == FRAME_MULTI);
      if (accept_s) begin
        key_code <= cand_n_s;
        key_held <= 1'b1;
      end else if (release_s) begin
        key_held <= 1'b0;
      end else begin
        key_held <= key_held;
      end
    end
  end

endmodule

// File: tb/tb_keypad_col_decoder.sv
// Scoreboard bench for keypad_col_decoder: directed key frames push expected
// events; a negedge monitor pops and compares them as the DUT reports them.
module tb_keypad_col_decoder;

  localparam int EV_VALID   = 0;
  localparam int EV_MULTI   = 1;
  localparam int EV_RELEASE = 2;

  typedef struct {
    int         kind;
    logic [3:0] code;
    int         stamp;
  } exp_t;

  logic       clk_sec = 1'b0;
  logic       rst_n;
  logic [3:0] row_drive;
  logic [3:0] col_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  logic rst_seen = 1'b1;
  logic prev_held = 1'b0;

  keypad_col_decoder #(.DEBOUNCE_FRAMES(3), .COL_W(4)) dut (
    .clk_sec   (clk_sec),
    .rst_n     (rst_n),
    .row_drive (row_drive),
    .col_in    (col_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  always #5 clk_sec = ~clk_sec;

  always @(posedge clk_sec) begin
    edge_cnt <= edge_cnt + 1;
    rst_seen <= !rst_n;
  end

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic check_event(input int kind, input logic [3:0] code);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d code %0h at edge %0d, expected none", kind, code, edge_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.stamp != edge_cnt ||
          (kind != EV_MULTI && e.code !== code)) begin
        errors++;
        $display("FAIL event: got kind %0d code %0h edge %0d, expected kind %0d code %0h edge %0d",
                 kind, code, edge_cnt, e.kind, e.code, e.stamp);
      end
    end
  endtask

  // Monitor: turn DUT output activity into events and score them.
  always @(negedge clk_sec) begin
    if (rst_seen === 1'b1) begin
      prev_held = 1'b0;
    end else begin
      if (key_valid === 1'b1) begin
        check_event(EV_VALID, key_code);
        cmp("held_on_valid", {3'b000, key_held}, 4'd1);
      end
      if (multi_err === 1'b1) begin
        check_event(EV_MULTI, 4'd0);
      end
      if (prev_held && key_held === 1'b0) begin
        check_event(EV_RELEASE, key_code);
      end
      prev_held = (key_held === 1'b1);
    end
  end

  task automatic push_exp(input int kind, input logic [3:0] code, input int close_stamp);
    exp_t e;
    e.kind  = kind;
    e.code  = code;
    e.stamp = close_stamp + 1;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] rv, input logic [3:0] cv);
    row_drive = rv;
    col_in    = cv;
    @(posedge clk_sec);
    #1;
  endtask

  function automatic logic [15:0] km(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  // One scan frame: four rows, optional illegal pattern after row 1, then the gap.
  task automatic do_frame(input logic [15:0] keys, input bit inject, output int close_stamp);
    logic [3:0] rv;
    logic [3:0] cv;
    for (int r = 0; r < 4; r++) begin
      rv = 4'b1000 >> r;
      for (int c = 0; c < 4; c++) begin
        cv[3-c] = keys[r*4+c];
      end
      step(rv, cv);
      if (inject && r == 1) begin
        step(4'b0110, 4'b0000);
      end
    end
    close_stamp = edge_cnt;
    step(4'b1111, 4'b0000);
  endtask

  task automatic frames(input logic [15:0] keys, input int n, output int close_stamp);
    for (int i = 0; i < n; i++) begin
      do_frame(keys, 1'b0, close_stamp);
    end
  endtask

  task automatic check_cleared(input string tag);
    cmp({tag, "_key_code"}, key_code, 4'd0);
    cmp({tag, "_key_valid"}, {3'b000, key_valid}, 4'd0);
    cmp({tag, "_key_held"}, {3'b000, key_held}, 4'd0);
    cmp({tag, "_multi_err"}, {3'b000, multi_err}, 4'd0);
  endtask

  initial begin
    int st;
    rst_n     = 1'b0;
    row_drive = 4'b1111;
    col_in    = 4'b0000;
    @(posedge clk_sec);
    #1;
    step(4'b1111, 4'b0000);
    step(4'b1111, 4'b0000);
    check_cleared("reset");
    rst_n = 1'b1;

    // Key 6 for 5 frames: first frame discarded, accepted after the 4th close.
    frames(km(6), 4, st);
    push_exp(EV_VALID, 4'd6, st);
    frames(km(6), 1, st);
    // Release for 3 frames.
    frames(16'h0000, 3, st);
    push_exp(EV_RELEASE, 4'd6, st);

    // Present 2, absent 1, present 3.
    frames(km(6), 2, st);
    frames(16'h0000, 1, st);
    frames(km(6), 3, st);
    push_exp(EV_VALID, 4'd6, st);
    frames(16'h0000, 3, st);
    push_exp(EV_RELEASE, 4'd6, st);

    // Multi-key frames in IDLE: keys 0+15, then two columns in one row.
    frames(km(0) | km(15), 1, st);
    push_exp(EV_MULTI, 4'd0, st);
    frames(km(4) | km(5), 1, st);
    push_exp(EV_MULTI, 4'd0, st);
    frames(km(3), 3, st);
    push_exp(EV_VALID, 4'd3, st);
    frames(16'h0000, 3, st);
    push_exp(EV_RELEASE, 4'd3, st);

    // Illegal row pattern in a key-9 frame delays acceptance by one frame.
    do_frame(km(9), 1'b1, st);
    frames(km(9), 3, st);
    push_exp(EV_VALID, 4'd9, st);
    // While pressed: other key ignored, multi flagged, short gap bounces back.
    frames(km(2), 1, st);
    frames(km(9) | km(10), 1, st);
    push_exp(EV_MULTI, 4'd0, st);
    frames(16'h0000, 1, st);
    frames(km(9), 1, st);

    // Reset while held: outputs clear, key re-debounced after the discard frame.
    rst_n = 1'b0;
    step(4'b1111, 4'b0000);
    check_cleared("midreset");
    rst_n = 1'b1;
    frames(km(9), 4, st);
    push_exp(EV_VALID, 4'd9, st);
    frames(16'h0000, 3, st);
    push_exp(EV_RELEASE, 4'd9, st);

    // Candidate restart, then a release bounce; key_code holds through release.
    frames(km(1), 1, st);
    frames(km(7), 3, st);
    push_exp(EV_VALID, 4'd7, st);
    frames(16'h0000, 2, st);
    frames(km(7), 1, st);
    frames(16'h0000, 3, st);
    push_exp(EV_RELEASE, 4'd7, st);

    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'b0000);
    end
    cmp("key_code_after_release", key_code, 4'd7);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
